uart_rx_frame: RTL and testbench

- 8N1-style UART receiver: deserialises the asynchronous serial line into bytes and presents them on a valid/ready output handshake.
- Opposite direction of the transmit path.
- Sits between the rxd pad and the core's UART rx interface (`uart_rx_data_o` / `uart_rx_valid_o` / `uart_rx_ready_i`).
- Shares the `uart_prescale` convention with the transmitter: one bit time = prescale*8 hwclk cycles.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx_frame.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
//   OVERSAMPLE      : clocks per bit per unit of prescale
//   DATA_WIDTH_DEF  : default data bits per frame
//   PRESCALE_W_DEF  : default width of the prescale input
//   rx_state_e      : receiver frame state
package uart_pkg;

  localparam int unsigned OVERSAMPLE     = 8;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PRESCALE_W_DEF = 16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver (start, DATA_WIDTH data bits LSB first, one stop bit).
// Deserialises rxd and presents each byte on a valid/ready handshake.
//   hwclk           : system clock
//   reset_n         : asynchronous active-low reset
//   rxd             : asynchronous serial input, idles high
//   prescale        : bit time = prescale*8 clocks, captured at start detect
//   rx_data_o       : received byte
//   rx_valid_o      : rx_data_o holds an unconsumed byte
//   rx_ready_i      : consumer takes the byte this cycle
//   busy_o          : frame reception in progress
//   overrun_error_o : pulse, new byte overwrote an unconsumed one
//   frame_error_o   : pulse, stop bit sampled low
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  hwclk,
  input  logic                  reset_n,
  input  logic                  rxd,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  busy_o,
  output logic                  overrun_error_o,
  output logic                  frame_error_o
);

  localparam int unsigned CNT_W = PRESCALE_W + 3;
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  // Clock count of 'mult' oversample ticks minus one, for a given prescale.
  function automatic logic [CNT_W-1:0] ticks_m1(input logic [PRESCALE_W-1:0] pv,
                                                input int unsigned          mult);
    return (CNT_W'(pv) * CNT_W'(mult)) - CNT_W'(1);
  endfunction

  logic rxd_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rxd (
    .clk   (hwclk),
    .rst_n (reset_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  rx_state_e             state_q,    state_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  logic [IDX_W-1:0]      bit_idx_q,  bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q,    shift_d;
  logic [PRESCALE_W-1:0] pv_q,       pv_d;
  logic                  rxd_d3_q,   rxd_d3_d;
  logic [1:0]            flush_q,    flush_d;
  logic                  armed_q,    armed_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic                  valid_q,    valid_d;
  logic                  busy_q,     busy_d;
  logic                  ovr_q,      ovr_d;
  logic                  ferr_q,     ferr_d;

  logic                  flushed;
  logic                  fall;
  logic                  deliver;
  logic [PRESCALE_W-1:0] pv_in;
  logic [DATA_WIDTH:0]   shift_ext;

  // Synchroniser output is only meaningful two clocks after reset release.
  assign flushed = (flush_q == 2'd2);
  // Start edges are accepted only once the line has been seen high since reset.
  assign fall      = armed_q & rxd_d3_q & ~rxd_s;
  assign pv_in     = (prescale == '0) ? PRESCALE_W'(1) : prescale;
  assign shift_ext = {rxd_s, shift_q};

  // Next-state, datapath and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pv_d      = pv_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ovr_d     = 1'b0;
    ferr_d    = 1'b0;
    deliver   = 1'b0;
    rxd_d3_d  = rxd_s;
    flush_d   = flushed ? flush_q : flush_q + 2'd1;
    armed_d   = armed_q | (flushed & rxd_s);

    unique case (state_q)
      RX_IDLE: begin
        if (fall) begin
          pv_d    = pv_in;
          cnt_d   = ticks_m1(pv_in, OVERSAMPLE / 2);
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rxd_s) begin
            cnt_d     = ticks_m1(pv_q, OVERSAMPLE);
            bit_idx_d = '0;
            state_d   = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d   = shift_ext[DATA_WIDTH:1];
          cnt_d     = ticks_m1(pv_q, OVERSAMPLE);
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          deliver = rxd_s;
          ferr_d  = ~rxd_s;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase

    // Output handshake; a delivery wins over a same-cycle consume.
    if (deliver) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rx_ready_i;
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge hwclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      pv_q      <= '0;
      rxd_d3_q  <= 1'b1;
      flush_q   <= 2'd0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      pv_q      <= pv_d;
      rxd_d3_q  <= rxd_d3_d;
      flush_q   <= flush_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data_o       = data_q;
  assign rx_valid_o      = valid_q;
  assign busy_o          = busy_q;
  assign overrun_error_o = ovr_q;
  assign frame_error_o   = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table of single frames plus
// hand-written backpressure, glitch, reset and same-cycle handshake cases.
module tb_uart_rx_frame;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;

  logic          hwclk = 1'b0;
  logic          reset_n;
  logic          rxd;
  logic [PW-1:0] prescale;
  logic [DW-1:0] rx_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic          busy_o;
  logic          overrun_error_o;
  logic          frame_error_o;

  always #5 hwclk = ~hwclk;

  uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .hwclk           (hwclk),
    .reset_n         (reset_n),
    .rxd             (rxd),
    .prescale        (prescale),
    .rx_data_o       (rx_data_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i),
    .busy_o          (busy_o),
    .overrun_error_o (overrun_error_o),
    .frame_error_o   (frame_error_o)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  int n_deliv = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: detect each new delivery and compare against the oldest expected byte.
  always @(negedge hwclk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (frame_error_o) n_ferr++;
      if (overrun_error_o) n_ovr++;
      if (rx_valid_o && (!prev_valid || prev_ready || overrun_error_o)) begin
        n_deliv++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got 0x%0h with no byte expected", rx_data_o);
        end else begin
          chk("rx_data", 32'(rx_data_o), 32'(exp_q.pop_front()));
        end
      end
      prev_valid = rx_valid_o;
      prev_ready = rx_ready_i;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge hwclk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input int pv);
    int bt;
    bt = ((pv == 0) ? 1 : pv) * 8;
    rxd = 1'b0;
    cyc(bt);
    for (int i = 0; i < int'(DW); i++) begin
      rxd = d[i];
      cyc(bt);
    end
    rxd = stop;
    cyc(bt);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    int            pv;
    int            exp_deliv;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, f0, o0, tot;
    logic seen;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, pv: 1, exp_deliv: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h55, stop: 1'b0, pv: 1, exp_deliv: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'h12, stop: 1'b1, pv: 1, exp_deliv: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h00, stop: 1'b1, pv: 3, exp_deliv: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, pv: 2, exp_deliv: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'h7E, stop: 1'b1, pv: 0, exp_deliv: 1, exp_ferr: 0};

    reset_n    = 1'b0;
    rxd        = 1'b1;
    rx_ready_i = 1'b1;
    prescale   = PW'(1);
    cyc(3);
    chk("reset_data",  32'(rx_data_o), 32'h0);
    chk("reset_valid", 32'(rx_valid_o), 32'h0);
    chk("reset_busy",  32'(busy_o), 32'h0);
    chk("reset_ovr",   32'(overrun_error_o), 32'h0);
    chk("reset_ferr",  32'(frame_error_o), 32'h0);
    reset_n = 1'b1;
    cyc(5);

    // Single frames with the consumer always ready.
    foreach (vecs[i]) begin
      prescale = PW'(vecs[i].pv);
      d0 = n_deliv; f0 = n_ferr; o0 = n_ovr;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].pv);
      cyc(4);
      chk($sformatf("v%0d_deliveries", i), 32'(n_deliv - d0), 32'(vecs[i].exp_deliv));
      chk($sformatf("v%0d_frame_err", i),  32'(n_ferr - f0),  32'(vecs[i].exp_ferr));
      chk($sformatf("v%0d_overrun", i),    32'(n_ovr - o0),   32'h0);
      chk($sformatf("v%0d_busy_idle", i),  32'(busy_o),       32'h0);
      chk($sformatf("v%0d_valid_idle", i), 32'(rx_valid_o),   32'h0);
    end

    // Back-to-back frames under backpressure: second overwrites first.
    rx_ready_i = 1'b0;
    prescale   = PW'(2);
    o0 = n_ovr;
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hC3);
    send_frame(8'h3C, 1'b1, 2);
    chk("bp_first_valid", 32'(rx_valid_o), 32'h1);
    chk("bp_first_data",  32'(rx_data_o), 32'h3C);
    send_frame(8'hC3, 1'b1, 2);
    cyc(4);
    chk("bp_overrun_once", 32'(n_ovr - o0), 32'h1);
    chk("bp_second_data",  32'(rx_data_o), 32'hC3);
    chk("bp_second_valid", 32'(rx_valid_o), 32'h1);
    rx_ready_i = 1'b1;
    cyc(1);
    chk("bp_valid_drop", 32'(rx_valid_o), 32'h0);

    // Short low glitch must be rejected at the start-bit sample.
    prescale = PW'(4);
    d0 = n_deliv; f0 = n_ferr;
    rxd = 1'b0;
    cyc(3);
    rxd = 1'b1;
    seen = 1'b0;
    tot = 3;
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      tot++;
      if (busy_o) seen = 1'b1;
      if (seen && !busy_o) break;
    end
    chk("glitch_busy_seen",  32'(seen), 32'h1);
    chk("glitch_busy_low",   32'(busy_o), 32'h0);
    chk("glitch_recover_in_time", 32'(tot <= 23), 32'h1);
    chk("glitch_no_deliv",   32'(n_deliv - d0), 32'h0);
    chk("glitch_no_ferr",    32'(n_ferr - f0), 32'h0);

    // Reset during data bit 4 of 0xFF, then a held-low line must not start.
    prescale = PW'(1);
    rx_ready_i = 1'b1;
    rxd = 1'b0;
    cyc(8);
    rxd = 1'b1;
    cyc(36);
    chk("mid_frame_busy", 32'(busy_o), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_data",  32'(rx_data_o), 32'h0);
    chk("async_reset_valid", 32'(rx_valid_o), 32'h0);
    chk("async_reset_busy",  32'(busy_o), 32'h0);
    rxd = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      cyc(1);
      if (busy_o) seen = 1'b1;
    end
    chk("held_low_no_start", 32'(seen), 32'h0);
    rxd = 1'b1;
    cyc(10);
    d0 = n_deliv; f0 = n_ferr;
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1);
    cyc(4);
    chk("post_reset_deliv", 32'(n_deliv - d0), 32'h1);
    chk("post_reset_ferr",  32'(n_ferr - f0), 32'h0);

    // prescale = 0, then ready pulsed exactly on the next delivery edge.
    rx_ready_i = 1'b0;
    prescale   = PW'(0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 0);
    cyc(4);
    chk("p0_valid", 32'(rx_valid_o), 32'h1);
    chk("p0_data",  32'(rx_data_o), 32'h7E);
    o0 = n_ovr;
    exp_q.push_back(8'h01);
    fork
      send_frame(8'h01, 1'b1, 0);
      begin
        // Delivery edge is 79 clocks after the start bit is driven.
        cyc(78);
        rx_ready_i = 1'b1;
        cyc(1);
        rx_ready_i = 1'b0;
      end
    join
    cyc(4);
    chk("hs_no_overrun", 32'(n_ovr - o0), 32'h0);
    chk("hs_valid",      32'(rx_valid_o), 32'h1);
    chk("hs_data",       32'(rx_data_o), 32'h01);
    rx_ready_i = 1'b1;
    cyc(2);
    chk("hs_drained_valid", 32'(rx_valid_o), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
